// File: rtl/edid_ddc_reader.sv
// EDID reader over DDC (I2C master): pulls NUM_BYTES from DEV_ADDR,
// streams each byte out and reports ACK errors and the checksum result.
module edid_ddc_reader #(
  parameter int         CLK_DIV   = 125,
  parameter int         NUM_BYTES = 128,
  parameter logic [6:0] DEV_ADDR  = 7'h50
) (
  input  logic       I_clk,
  input  logic       I_rst,
  input  logic       I_start,
  input  logic       I_scl,
  input  logic       I_sda,
  output logic       O_scl_oe,
  output logic       O_sda_oe,
  output logic       O_busy,
  output logic       O_byte_valid,
  output logic [6:0] O_byte_addr,
  output logic [7:0] O_byte_data,
  output logic       O_done,
  output logic       O_ack_err,
  output logic       O_csum_ok
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [6:0] LAST = 7'(NUM_BYTES - 1);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_START   = 4'd1;
  localparam logic [3:0] S_WR_BYTE = 4'd2;
  localparam logic [3:0] S_WR_ACK  = 4'd3;
  localparam logic [3:0] S_RSTART  = 4'd4;
  localparam logic [3:0] S_RD_BYTE = 4'd5;
  localparam logic [3:0] S_RD_ACK  = 4'd6;
  localparam logic [3:0] S_STOP    = 4'd7;
  localparam logic [3:0] S_DONE    = 4'd8;

  logic [3:0]    state;
  logic [1:0]    q;
  logic [DW-1:0] div_cnt;
  logic [2:0]    bit_cnt;
  logic [1:0]    wr_idx;
  logic [7:0]    tx;
  logic [7:0]    rx;
  logic [6:0]    byte_cnt;
  logic [7:0]    csum;
  logic [7:0]    rx_next;
  logic          active;
  logic          stall;
  logic          tick;
  logic          sample;
  logic          bit_end;
  logic          last_byte;

  assign active    = (state != S_IDLE) && (state != S_DONE);
  // A slave holding SCL low during Q2 restarts the quarter,
  // so the high phase is always a full quarter long.
  assign stall     = (q == 2'd2) && !I_scl;
  assign tick      = active && !stall && (div_cnt == DIV_MAX);
  assign sample    = tick && (q == 2'd2);
  assign bit_end   = tick && (q == 2'd3);
  assign last_byte = (byte_cnt == LAST);
  assign rx_next   = {rx[6:0], I_sda};

  assign O_busy = active;
  assign O_done = (state == S_DONE);

  always_comb begin
    O_scl_oe = 1'b0;
    O_sda_oe = 1'b0;
    case (state)
      S_START: O_sda_oe = (q == 2'd3);
      S_WR_BYTE: begin
        O_scl_oe = ~q[1];
        O_sda_oe = ~tx[7];
      end
      S_WR_ACK, S_RD_BYTE: O_scl_oe = ~q[1];
      S_RSTART: begin
        O_scl_oe = ~q[1];
        O_sda_oe = (q == 2'd3);
      end
      S_RD_ACK: begin
        O_scl_oe = ~q[1];
        O_sda_oe = ~last_byte;
      end
      S_STOP: begin
        O_scl_oe = ~q[1];
        O_sda_oe = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state        <= S_IDLE;
      q            <= 2'd0;
      div_cnt      <= '0;
      bit_cnt      <= 3'd0;
      wr_idx       <= 2'd0;
      tx           <= 8'd0;
      rx           <= 8'd0;
      byte_cnt     <= 7'd0;
      csum         <= 8'd0;
      O_ack_err    <= 1'b0;
      O_csum_ok    <= 1'b0;
      O_byte_valid <= 1'b0;
      O_byte_addr  <= 7'd0;
      O_byte_data  <= 8'd0;
    end else begin
      O_byte_valid <= 1'b0;
      if (active) begin
        if (stall || div_cnt == DIV_MAX) div_cnt <= '0;
        else div_cnt <= div_cnt + 1'b1;
        if (tick) q <= q + 2'd1;
      end
      case (state)
        S_IDLE: begin
          if (I_start) begin
            state     <= S_START;
            q         <= 2'd0;
            div_cnt   <= '0;
            bit_cnt   <= 3'd0;
            wr_idx    <= 2'd0;
            byte_cnt  <= 7'd0;
            csum      <= 8'd0;
            tx        <= {DEV_ADDR, 1'b0};
            O_ack_err <= 1'b0;
            O_csum_ok <= 1'b0;
          end
        end
        S_START: if (bit_end) state <= S_WR_BYTE;
        S_WR_BYTE: begin
          if (bit_end) begin
            tx      <= {tx[6:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= S_WR_ACK;
          end
        end
        S_WR_ACK: begin
          if (sample && I_sda) O_ack_err <= 1'b1;
          if (bit_end) begin
            if (O_ack_err) state <= S_STOP;
            else if (wr_idx == 2'd0) begin
              tx     <= 8'h00;
              wr_idx <= 2'd1;
              state  <= S_WR_BYTE;
            end else if (wr_idx == 2'd1) begin
              tx     <= {DEV_ADDR, 1'b1};
              wr_idx <= 2'd2;
              state  <= S_RSTART;
            end else state <= S_RD_BYTE;
          end
        end
        S_RSTART: if (bit_end) state <= S_WR_BYTE;
        S_RD_BYTE: begin
          if (sample) begin
            rx <= rx_next;
            if (bit_cnt == 3'd7) begin
              O_byte_valid <= 1'b1;
              O_byte_data  <= rx_next;
              O_byte_addr  <= byte_cnt;
              csum         <= csum + rx_next;
            end
          end
          if (bit_end) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= S_RD_ACK;
          end
        end
        S_RD_ACK: begin
          if (bit_end) begin
            if (last_byte) state <= S_STOP;
            else begin
              byte_cnt <= byte_cnt + 7'd1;
              state    <= S_RD_BYTE;
            end
          end
        end
        S_STOP: begin
          if (bit_end) begin
            state     <= S_DONE;
            O_csum_ok <= (csum == 8'd0) && !O_ack_err;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_edid_ddc_reader.sv
// Bench for edid_ddc_reader: behavioural DDC slave with random EDID
// contents, NACK, clock stretching, bad checksum and mid-read reset.
module tb_edid_ddc_reader;

  localparam int CLK_DIV   = 3;
  localparam int NUM_BYTES = 128;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       scl_oe, sda_oe, busy, bvalid, done;
  logic       ack_err, csum_ok;
  logic [6:0] baddr;
  logic [7:0] bdata;
  logic       s_scl_low = 1'b0;
  logic       s_sda_low = 1'b0;
  logic       scl, sda;

  assign scl = ~(scl_oe | s_scl_low);
  assign sda = ~(sda_oe | s_sda_low);

  edid_ddc_reader #(
    .CLK_DIV(CLK_DIV),
    .NUM_BYTES(NUM_BYTES),
    .DEV_ADDR(7'h50)
  ) dut (
    .I_clk(clk),
    .I_rst(rst),
    .I_start(start),
    .I_scl(scl),
    .I_sda(sda),
    .O_scl_oe(scl_oe),
    .O_sda_oe(sda_oe),
    .O_busy(busy),
    .O_byte_valid(bvalid),
    .O_byte_addr(baddr),
    .O_byte_data(bdata),
    .O_done(done),
    .O_ack_err(ack_err),
    .O_csum_ok(csum_ok)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  logic [7:0] mem [NUM_BYTES];

  function automatic logic [7:0] mem_sum();
    logic [7:0] s = 8'd0;
    for (int i = 0; i < NUM_BYTES; i++) s = s + mem[i];
    return s;
  endfunction

  task automatic init_mem();
    logic [7:0] hdr [8] = '{8'h00, 8'hFF, 8'hFF, 8'hFF,
                            8'hFF, 8'hFF, 8'hFF, 8'h00};
    for (int i = 0; i < NUM_BYTES - 1; i++)
      mem[i] = (i < 8) ? hdr[i] : 8'($urandom);
    mem[NUM_BYTES-1] = 8'd0;
    mem[NUM_BYTES-1] = 8'd0 - mem_sum();
  endtask

  // slave model state
  bit         nack_cfg = 0;
  bit         stretch_en = 0;
  bit         stretched = 0;
  int         s_stretch = 0;
  int         mode = 0;
  int         bits = 0;
  bit         in_ack = 0;
  bit         rd_mode = 0;
  int         rx_no = 0;
  int         ptr = 0;
  logic [7:0] rxsh = 8'd0;
  logic [7:0] txsh = 8'd0;
  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;
  logic [7:0] rx_log [$];
  int         stop_cnt = 0;
  int         mack_cnt = 0;
  bit         last_mack = 0;

  task automatic send_first();
    txsh = mem[ptr % NUM_BYTES];
    s_sda_low = !txsh[7];
    bits = 1;
    if (stretch_en && !stretched && ptr == 5) begin
      stretched = 1;
      s_scl_low = 1'b1;
      s_stretch = 500;
    end
  endtask

  always @(negedge clk) begin : slave
    logic cs, cd;
    cs = scl;
    cd = sda;
    if (rst) begin
      mode = 0; in_ack = 0; s_sda_low = 1'b0;
      s_scl_low = 1'b0; s_stretch = 0;
    end else begin
      if (s_stretch > 0) begin
        s_stretch--;
        if (s_stretch == 0) s_scl_low = 1'b0;
      end
      if (prev_scl && cs && prev_sda && !cd) begin
        mode = 1; bits = 0; in_ack = 0; rx_no = 0;
        s_sda_low = 1'b0;
      end else if (prev_scl && cs && !prev_sda && cd) begin
        mode = 0; stop_cnt++; s_sda_low = 1'b0;
      end else if (!prev_scl && cs) begin
        if (mode == 1 && !in_ack) begin
          rxsh = {rxsh[6:0], cd};
          bits++;
        end else if (mode == 2 && in_ack) begin
          last_mack = cd;
          if (!cd) mack_cnt++;
        end
      end else if (prev_scl && !cs) begin
        if (mode == 1) begin
          if (in_ack) begin
            in_ack = 0; s_sda_low = 1'b0; bits = 0;
            if (rd_mode) begin
              mode = 2;
              send_first();
            end
          end else if (bits == 8) begin
            rx_log.push_back(rxsh);
            if (rx_no == 0) begin
              rd_mode = rxsh[0];
              if (rxsh[7:1] == 7'h50 && !nack_cfg) begin
                s_sda_low = 1'b1; in_ack = 1;
              end else mode = 0;
            end else begin
              ptr = int'(rxsh);
              s_sda_low = 1'b1; in_ack = 1;
            end
            rx_no++;
          end
        end else if (mode == 2) begin
          if (in_ack) begin
            in_ack = 0;
            if (!last_mack) begin
              ptr++;
              send_first();
            end else begin
              s_sda_low = 1'b0; mode = 0;
            end
          end else if (bits < 8) begin
            s_sda_low = !txsh[7-bits];
            bits++;
          end else begin
            s_sda_low = 1'b0; in_ack = 1;
          end
        end
      end
    end
    prev_scl = scl;
    prev_sda = sda;
  end

  // output monitor
  int strobe_n = 0;
  int done_cnt = 0;
  int got_strobes = 0;
  logic got_csum = 0;
  logic got_ack = 0;
  int hi_run = 0;
  int min_hi = 1000000;

  always @(negedge clk) begin
    if (!rst) begin
      if (bvalid) begin
        check("strobe_addr", 32'(baddr), 32'(strobe_n % 128));
        check("strobe_data", 32'(bdata),
              32'(mem[strobe_n % NUM_BYTES]));
        strobe_n++;
      end
      if (done) begin
        done_cnt++;
        got_csum = csum_ok;
        got_ack = ack_err;
        got_strobes = strobe_n;
        check("busy_at_done", 32'(busy), 32'd0);
      end
    end
    if (scl) hi_run++;
    else begin
      if (hi_run > 0 && hi_run < min_hi) min_hi = hi_run;
      hi_run = 0;
    end
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic run_txn(input string nm, input bit nack,
                         input int extra);
    int d0, s0;
    bit exp_ok;
    rx_log.delete();
    strobe_n = 0; mack_cnt = 0; last_mack = 0;
    min_hi = 1000000; stretched = 0;
    d0 = done_cnt; s0 = stop_cnt;
    exp_ok = !nack && (mem_sum() == 8'd0);
    pulse_start();
    check({nm, "_busy"}, 32'(busy), 32'd1);
    for (int k = 0; k < extra; k++) begin
      repeat ($urandom_range(2000, 200)) @(negedge clk);
      pulse_start();
    end
    for (int i = 0; i < 30000 && done_cnt == d0; i++)
      @(negedge clk);
    if (done_cnt == d0) check({nm, "_timeout"}, 32'd0, 32'd1);
    repeat (20) @(negedge clk);
    check({nm, "_done_once"}, 32'(done_cnt - d0), 32'd1);
    check({nm, "_strobes"}, 32'(got_strobes),
          nack ? 32'd0 : 32'(NUM_BYTES));
    check({nm, "_ack_err"}, 32'(got_ack), 32'(nack));
    check({nm, "_csum_ok"}, 32'(got_csum), 32'(exp_ok));
    check({nm, "_stop"}, 32'(stop_cnt - s0), 32'd1);
    check({nm, "_wr_n"}, 32'(rx_log.size()), nack ? 32'd1 : 32'd3);
    if (rx_log.size() > 0)
      check({nm, "_dev_w"}, 32'(rx_log[0]), 32'hA0);
    if (!nack && rx_log.size() == 3) begin
      check({nm, "_waddr"}, 32'(rx_log[1]), 32'h00);
      check({nm, "_dev_r"}, 32'(rx_log[2]), 32'hA1);
    end
    if (!nack) begin
      check({nm, "_macks"}, 32'(mack_cnt), 32'(NUM_BYTES - 1));
      check({nm, "_last_nack"}, 32'(last_mack), 32'd1);
    end
    check({nm, "_scl_hi"}, 32'(min_hi >= CLK_DIV), 32'd1);
    check({nm, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    init_mem();
    repeat (3) @(negedge clk);
    check("rst_scl_oe", 32'(scl_oe), 32'd0);
    check("rst_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_valid", 32'(bvalid), 32'd0);
    check("rst_ack_err", 32'(ack_err), 32'd0);
    check("rst_csum_ok", 32'(csum_ok), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    run_txn("norm", 0, 3);

    nack_cfg = 1;
    run_txn("nack", 1, 0);
    nack_cfg = 0;

    init_mem();
    stretch_en = 1;
    run_txn("strch", 0, 0);
    check("strch_hit", 32'(stretched), 32'd1);
    stretch_en = 0;

    init_mem();
    mem[NUM_BYTES-1] = mem[NUM_BYTES-1] + 8'd1;
    run_txn("badsum", 0, 0);

    init_mem();
    strobe_n = 0;
    pulse_start();
    for (int i = 0; i < 10000 && strobe_n < 40; i++)
      @(negedge clk);
    check("rst_reach40", 32'(strobe_n >= 40), 32'd1);
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_scl_oe", 32'(scl_oe), 32'd0);
    check("mid_rst_sda_oe", 32'(sda_oe), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    run_txn("post", 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
